stopwatch_timekeeper: RTL

- Produces the minutes/seconds pair that the stopwatch's seven-segment display driver consumes; it is the source end of the minutes/seconds interface.
- Conditions two raw push-buttons (start/stop, clear) with synchronisers, debouncers and edge detectors.
- Runs a start/stop/pause state machine and a prescaled 1 Hz time-of-count in range 00:00 to 59:59.

---
 rtl/stopwatch_timekeeper.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_timekeeper.sv
// Stopwatch timekeeper: source end of the minutes/seconds interface feeding the
// seven-segment display driver.
//
// Raw push-buttons are synchronised (2-FF), debounced (level changes only after
// DEBOUNCE_CYCLES consecutive differing synchronised cycles) and edge-detected into
// one-cycle press pulses. A start/stop/pause FSM gates a prescaler that produces a
// 1 Hz tick, which advances a 00:00..59:59 count with a sticky overflow flag.
//
// Optional build macro: STOPWATCH_LAP_HOLD_EN
//   When defined, btn_lap is conditioned like the other buttons and a lap press while
//   running toggles a display hold (outputs freeze, internal counting continues).
//   When undefined, btn_lap is ignored and the outputs always show the live count.
//
// Parameters:
//   CLK_HZ          - clock cycles per counted second
//   DEBOUNCE_CYCLES - stable synchronised cycles before a debounced level changes
//
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous, active-high reset
//   btn_start_stop in   raw start/stop button (asynchronous, active-high)
//   btn_clear      in   raw clear button (asynchronous, active-high)
//   btn_lap        in   raw lap button (only used with STOPWATCH_LAP_HOLD_EN)
//   minutes        out  displayed minutes, 0..59
//   seconds        out  displayed seconds, 0..59
//   running        out  high while the FSM is in the running state
//   overflow       out  sticky, set when the count wraps 59:59 -> 00:00

module stopwatch_timekeeper #(
    parameter int unsigned CLK_HZ          = 100000000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       overflow
);

    localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PW-1:0] PrescMax = PW'(CLK_HZ - 1);
    localparam logic [CW-1:0] CntMax   = CW'(DEBOUNCE_CYCLES - 1);

    localparam int unsigned IdxSs  = 0;
    localparam int unsigned IdxClr = 1;

`ifdef STOPWATCH_LAP_HOLD_EN
    localparam int unsigned NB     = 3;
    localparam int unsigned IdxLap = 2;
`else
    localparam int unsigned NB     = 2;
`endif

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StPaused  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [NB-1:0] deb_q;
    logic [NB-1:0] deb_prev_q;
    logic [CW-1:0] cnt_q [NB];
    logic [NB-1:0] press;

`ifdef STOPWATCH_LAP_HOLD_EN
    assign btn_raw = {btn_lap, btn_clear, btn_start_stop};
`else
    assign btn_raw = {btn_clear, btn_start_stop};
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int i = 0; i < int'(NB); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            deb_prev_q <= deb_q;
            for (int i = 0; i < int'(NB); i++) begin
                if (sync2_q[i] == deb_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CntMax) begin
                    // Differed for DEBOUNCE_CYCLES consecutive cycles: accept new level.
                    deb_q[i] <= sync2_q[i];
                    cnt_q[i] <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // One-cycle pulse in the cycle after a debounced rising transition.
    assign press = deb_q & ~deb_prev_q;

    logic ss_pulse;
    logic clr_pulse;
    assign ss_pulse  = press[IdxSs];
    assign clr_pulse = press[IdxClr];

    // ------------------------------------------------------------------
    // FSM and time-of-count
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    sec_q, sec_d;
    logic [5:0]    min_q, min_d;
    logic          ovf_q, ovf_d;
    logic          running_q, running_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            ovf_q     <= ovf_d;
            running_q <= running_d;
        end
    end

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        sec_d   = sec_q;
        min_d   = min_q;
        ovf_d   = ovf_q;

        if (clr_pulse) begin
            // Clear dominates any simultaneous start/stop press.
            state_d = StIdle;
            presc_d = '0;
            sec_d   = '0;
            min_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            if (state_q == StRunning) begin
                if (presc_q == PrescMax) begin
                    presc_d = '0;
                    if (sec_q == 6'd59) begin
                        sec_d = '0;
                        if (min_q == 6'd59) begin
                            min_d = '0;
                            ovf_d = 1'b1;
                        end else begin
                            min_d = min_q + 6'd1;
                        end
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end

            if (ss_pulse) begin
                unique case (state_q)
                    StIdle: begin
                        state_d = StRunning;
                        presc_d = '0;
                    end
                    // Prescaler simply stops advancing, keeping the fractional second.
                    StRunning: state_d = StPaused;
                    StPaused:  state_d = StRunning;
                    default:   state_d = StIdle;
                endcase
            end
        end

        running_d = (state_d == StRunning);
    end

    assign running  = running_q;
    assign overflow = ovf_q;

    // ------------------------------------------------------------------
    // Display path
    // ------------------------------------------------------------------
`ifdef STOPWATCH_LAP_HOLD_EN
    logic       lap_pulse;
    logic       hold_q, hold_d;
    logic [5:0] hold_min_q, hold_min_d;
    logic [5:0] hold_sec_q, hold_sec_d;

    assign lap_pulse = press[IdxLap];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hold_q     <= 1'b0;
            hold_min_q <= '0;
            hold_sec_q <= '0;
        end else begin
            hold_q     <= hold_d;
            hold_min_q <= hold_min_d;
            hold_sec_q <= hold_sec_d;
        end
    end

    always_comb begin
        hold_d     = hold_q;
        hold_min_d = hold_min_q;
        hold_sec_d = hold_sec_q;
        if (clr_pulse) begin
            hold_d = 1'b0;
        end else if (lap_pulse && (state_q == StRunning)) begin
            hold_d = ~hold_q;
            if (!hold_q) begin
                // Capture the count as displayed when the lap press lands.
                hold_min_d = min_q;
                hold_sec_d = sec_q;
            end
        end
    end

    assign minutes = hold_q ? hold_min_q : min_q;
    assign seconds = hold_q ? hold_sec_q : sec_q;
`else
    assign minutes = min_q;
    assign seconds = sec_q;
`endif

endmodule
